// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register slave: a small bank of 32-bit registers with byte strobes.
// One write and one read may be outstanding at a time. Writes and reads to
// unmapped word offsets answer with SLVERR. Register contents go straight out
// to fabric logic on reg_q. wr_pulse flags each commit for one cycle.
module axi4lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR,
  input  logic [2:0]                        AWPROT,
  input  logic                              AWVALID,
  output logic                              AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                              WVALID,
  output logic                              WREADY,
  output logic [1:0]                        BRESP,
  output logic                              BVALID,
  input  logic                              BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR,
  input  logic [2:0]                        ARPROT,
  input  logic                              ARVALID,
  output logic                              ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                        RRESP,
  output logic                              RVALID,
  input  logic                              RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]               wr_pulse
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  // Merge new data into an old word, byte lane by byte lane, under the strobes.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_word,
                                                input logic [DW-1:0] new_word,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_word;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_word[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_word[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // True when a word index falls inside the implemented register bank.
  function automatic logic is_mapped(input logic [IDX_W-1:0] idx);
    return ({{(32-IDX_W){1'b0}}, idx} < 32'(NUM_REGS));
  endfunction

  logic [DW-1:0]    regs_r [NUM_REGS];
  logic             aw_full_r, w_full_r;
  logic [IDX_W-1:0] aw_idx_r;
  logic [DW-1:0]    w_data_r;
  logic [SW-1:0]    w_strb_r;
  logic             awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  logic [1:0]       bresp_r, rresp_r;
  logic [DW-1:0]    rdata_r;
  logic [NUM_REGS-1:0] wr_pulse_r;

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, commit_s;
  logic aw_mapped_s, ar_mapped_s;
  logic [IDX_W-1:0] ar_idx_s;
  logic aw_full_s, w_full_s, bvalid_s, rvalid_s;
  logic [DW-1:0] rd_word_s;
  logic unused_bits_s;

  // Address LSBs and protection bits carry no meaning for this bank.
  assign unused_bits_s = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  assign aw_hs_s     = AWVALID & awready_r;
  assign w_hs_s      = WVALID & wready_r;
  assign b_hs_s      = bvalid_r & BREADY;
  assign ar_hs_s     = ARVALID & arready_r;
  assign r_hs_s      = rvalid_r & RREADY;
  assign commit_s    = aw_full_r & w_full_r & ~bvalid_r;
  assign aw_mapped_s = is_mapped(aw_idx_r);
  assign ar_idx_s    = ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_mapped_s = is_mapped(ar_idx_s);

  // Next-state of the buffer and response flags; readies follow from these.
  always_comb begin
    aw_full_s = aw_full_r;
    w_full_s  = w_full_r;
    bvalid_s  = bvalid_r;
    rvalid_s  = rvalid_r;
    if (commit_s) begin
      aw_full_s = 1'b0;
      w_full_s  = 1'b0;
      bvalid_s  = 1'b1;
    end else begin
      if (aw_hs_s) begin
        aw_full_s = 1'b1;
      end else begin
        aw_full_s = aw_full_r;
      end
      if (w_hs_s) begin
        w_full_s = 1'b1;
      end else begin
        w_full_s = w_full_r;
      end
      if (b_hs_s) begin
        bvalid_s = 1'b0;
      end else begin
        bvalid_s = bvalid_r;
      end
    end
    if (ar_hs_s) begin
      rvalid_s = 1'b1;
    end else if (r_hs_s) begin
      rvalid_s = 1'b0;
    end else begin
      rvalid_s = rvalid_r;
    end
  end

  // Read mux over the register bank; unmatched indices yield zero.
  always_comb begin
    rd_word_s = {DW{1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      rd_word_s = (ar_idx_s == IDX_W'(k)) ? regs_r[k] : rd_word_s;
    end
  end

  // Handshake flags and registered readies (ready only while nothing pending).
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      rvalid_r  <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      arready_r <= 1'b0;
    end else begin
      aw_full_r <= aw_full_s;
      w_full_r  <= w_full_s;
      bvalid_r  <= bvalid_s;
      rvalid_r  <= rvalid_s;
      awready_r <= ~aw_full_s & ~bvalid_s;
      wready_r  <= ~w_full_s & ~bvalid_s;
      arready_r <= ~rvalid_s;
    end
  end

  // Capture the write address and the write data/strobes on their handshakes.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_idx_r <= {IDX_W{1'b0}};
      w_data_r <= {DW{1'b0}};
      w_strb_r <= {SW{1'b0}};
    end else begin
      if (aw_hs_s) begin
        aw_idx_r <= AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs_s) begin
        w_data_r <= WDATA;
        w_strb_r <= WSTRB;
      end
    end
  end

  // Register bank commit, commit pulse and write response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_r[k] <= {DW{1'b0}};
      end
      wr_pulse_r <= {NUM_REGS{1'b0}};
      bresp_r    <= 2'b00;
    end else begin
      wr_pulse_r <= {NUM_REGS{1'b0}};
      if (commit_s) begin
        bresp_r <= aw_mapped_s ? 2'b00 : 2'b10;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (aw_mapped_s && (aw_idx_r == IDX_W'(k))) begin
            regs_r[k]     <= merge_bytes(regs_r[k], w_data_r, w_strb_r);
            wr_pulse_r[k] <= 1'b1;
          end
        end
      end
    end
  end

  // Read response: sampled on the AR handshake and held until the R handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata_r <= {DW{1'b0}};
      rresp_r <= 2'b00;
    end else if (ar_hs_s) begin
      rdata_r <= ar_mapped_s ? rd_word_s : {DW{1'b0}};
      rresp_r <= ar_mapped_s ? 2'b00 : 2'b10;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[g*DW +: DW] = regs_r[g];
  end

  assign AWREADY  = awready_r;
  assign WREADY   = wready_r;
  assign BVALID   = bvalid_r;
  assign BRESP    = bresp_r;
  assign ARREADY  = arready_r;
  assign RVALID   = rvalid_r;
  assign RDATA    = rdata_r;
  assign RRESP    = rresp_r;
  assign wr_pulse = wr_pulse_r;

endmodule

// File: doc/axi4lite_reg_slave.md
# axi4lite_reg_slave

AXI4-Lite responder exposing a small bank of 32-bit read/write registers. It is the slave end of the AXI4-Lite master write/readback sequence our IP test benches run: write words to consecutive word offsets, then read them back and compare. It sits behind the interconnect in the block design and drives the register contents to fabric logic. It supports one outstanding write and one outstanding read, byte strobes, and error responses for unmapped offsets.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; word index = addr[ADDR_WIDTH-1:2].
- NUM_REGS, 4, number of implemented registers; 1..2^(ADDR_WIDTH-2).

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWPROT  in  3  ignored.
- AWVALID / AWREADY  in / out  1  write-address handshake.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables.
- WVALID / WREADY  in / out  1  write-data handshake.
- BRESP  out  2  00 = OKAY, 10 = SLVERR.
- BVALID / BREADY  out / in  1  write-response handshake.
- ARADDR  in  ADDR_WIDTH  read address.
- ARPROT  in  3  ignored.
- ARVALID / ARREADY  in / out  1  read-address handshake.
- RDATA  out  32  read data.
- RRESP  out  2  00 = OKAY, 10 = SLVERR.
- RVALID / RREADY  out / in  1  read-data handshake.
- reg_q  out  NUM_REGS*32  register contents; register k is at bits [32k+31:32k].
- wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle register k is committed.

## Operation
- Reset values: all registers are 0. AWREADY, WREADY, ARREADY, BVALID and RVALID are 0. BRESP, RRESP, RDATA and wr_pulse are 0.
- All outputs are registered. A ready that goes low on a handshake edge is low in the following cycle.
- Write path: the AW buffer and the W buffer fill independently, in either order or in the same cycle.
  - An AW handshake latches the address and drops AWREADY.
  - A W handshake latches WDATA/WSTRB and drops WREADY.
- Commit: when both buffers are full and BVALID=0, the next edge performs the commit.
  - Each byte b of the target register is updated where WSTRB[b]=1.
  - wr_pulse[idx] is set for that single cycle.
  - BVALID goes to 1 and both buffers clear.
- An index at or above NUM_REGS (unmapped): no register changes, no wr_pulse, BRESP=10.
- AWREADY and WREADY return to 1 on the edge after the B handshake (BVALID & BREADY). Only one write is outstanding at a time.
- Read path: ARREADY=1 when idle. On an AR handshake edge:
  - RDATA gets reg[idx], or 0 if unmapped.
  - RRESP gets 00, or 10 if unmapped.
  - RVALID goes to 1 and ARREADY goes to 0.
- ARREADY returns to 1 on the edge after the R handshake.
- RDATA, RRESP, BRESP and BVALID/RVALID hold stable until their handshake completes.
- Address bits [1:0] and the PROT inputs are ignored.
- WSTRB=0000: the write completes with OKAY, registers are unchanged, and wr_pulse still fires for a mapped index.

## Timing
- AW and W accepted together at edge t: the register updates, wr_pulse is high and BVALID=1 after edge t+1. With BREADY held at 1, AWREADY/WREADY are 1 again after edge t+2.
- W accepted k cycles before AW: the commit happens on the edge after the AW handshake.
- Read: AR handshake at edge t gives RVALID=1 with valid RDATA after edge t. With RREADY=1, ARREADY is 1 after edge t+1.
- A read handshake on the same edge as a commit to the same register returns the pre-commit value.
- Read and write channels are fully independent. There is no arbitration stall.
- BREADY held low: BVALID and BRESP hold. AWREADY/WREADY stay 0, and further AW/W are not accepted.
- ARESET asserted mid-transaction: all state returns to reset values immediately. Pending AW/W buffers and BVALID/RVALID are dropped. Registers clear.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back -> each BRESP=00, RDATA=1..4, RRESP=00, reg_q=0x00000004_00000003_00000002_00000001.
- W valid 3 cycles before AW (0x8, 0xDEADBEEF) -> WREADY drops after the W handshake; the commit, BVALID and wr_pulse=0100 occur on the edge after the AW handshake; readback 0xDEADBEEF.
- Reg0=0xFFFFFFFF, then write 0x12345678 with WSTRB=0101 -> reg0=0xFF34FF78; wr_pulse[0] is one cycle wide.
- Write and read address 0x10 -> BRESP=10, RRESP=10, RDATA=0, no wr_pulse, reg_q unchanged.
- Backpressure: BREADY=0 for 5 cycles with a second AW/W presented -> BVALID and BRESP held, AWREADY=WREADY=0; the second write commits only after the B handshake. Same-edge read of reg1 during a reg1 commit returns the old value.
- ARESET pulse while BVALID=1 and RVALID=1 -> all outputs 0, reg_q=0; after release, ready signals are 1 and a fresh write/read works.
